// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte/half/word load-store unit in front of a word-wide data
//            memory with combinational read and rising-edge write.
// Config   : MISALIGNED_SPLIT_EN - serve misaligned accesses (split across
//            two words when needed) instead of rejecting them.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] mem_idx,
    output logic [31:0]       mem_write_data,
    output logic              mem_write_enable,
    input  logic [31:0]       mem_read_data
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC0 = 2'd1;
    localparam logic [1:0] c_ACC1 = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_gather;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_error;

    logic [1:0]        w_req_size;
    logic              w_in_acc;
    logic              w_word_sel;
    logic              w_last_acc;
    logic [ADDR_W-1:0] w_base;
    logic [2:0]        w_nbytes;
    logic [3:0][2:0]   w_k;
    logic [3:0]        w_lane_hit;
    logic [3:0][7:0]   w_rd_b;
    logic [3:0][7:0]   w_wdata_b;
    logic [3:0][7:0]   w_merged;
    logic [3:0][7:0]   w_gather;
    logic [31:0]       w_ext;

    // Size code 11 behaves exactly like a word access from here on.
    assign w_req_size = (req_size == 2'b11) ? c_SZ_WORD : req_size;

`ifdef MISALIGNED_SPLIT_EN
    logic r_cross;
    logic w_cross;

    assign w_cross = ((w_req_size == c_SZ_HALF) && (req_addr[1:0] == 2'd3)) ||
                     ((w_req_size == c_SZ_WORD) && (req_addr[1:0] != 2'd0));
    assign w_last_acc = (r_state == c_ACC1) || !r_cross;
`else
    logic w_misaligned;

    assign w_misaligned = ((w_req_size == c_SZ_HALF) && req_addr[0]) ||
                          ((w_req_size == c_SZ_WORD) && (req_addr[1:0] != 2'd0));
    assign w_last_acc = 1'b1;
`endif

    assign w_in_acc   = (r_state == c_ACC0) || (r_state == c_ACC1);
    assign w_word_sel = (r_state == c_ACC1);
    assign w_base     = {r_addr[ADDR_W-1:2], 2'b00} +
                        (w_word_sel ? ADDR_W'(4) : ADDR_W'(0));

    always_comb begin
        case (r_size)
            c_SZ_BYTE: w_nbytes = 3'd1;
            c_SZ_HALF: w_nbytes = 3'd2;
            default:   w_nbytes = 3'd4;
        endcase
    end

    // Memory lane l carries access byte k = l + 4*word - offset (mod 8).
    // Out-of-range k wraps to 4..7 and is rejected by the k < nbytes test.
    always_comb begin
        w_rd_b    = mem_read_data;
        w_wdata_b = r_wdata;
        w_merged  = mem_read_data;
        w_gather  = r_gather;
        w_k       = '0;
        w_lane_hit = '0;
        for (int l = 0; l < 4; l++) begin
            w_k[l]        = 3'(l) + {w_word_sel, 2'b00} - {1'b0, r_addr[1:0]};
            w_lane_hit[l] = (w_k[l] < w_nbytes);
            if (w_lane_hit[l]) begin
                w_merged[l]              = w_wdata_b[w_k[l][1:0]];
                w_gather[w_k[l][1:0]]    = w_rd_b[l];
            end
        end
    end

    always_comb begin
        case (r_size)
            c_SZ_BYTE: w_ext = {{24{~r_unsigned & w_gather[0][7]}}, w_gather[0]};
            c_SZ_HALF: w_ext = {{16{~r_unsigned & w_gather[1][7]}}, w_gather[1], w_gather[0]};
            default:   w_ext = w_gather;
        endcase
    end

    assign req_ready        = (r_state == c_IDLE);
    assign mem_write_enable = w_in_acc & r_we;
    assign mem_idx          = w_in_acc ? w_base : '0;
    assign mem_write_data   = (w_in_acc & r_we) ? w_merged : '0;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_rdata        = r_rsp_rdata;
    assign rsp_error        = r_rsp_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_we        <= 1'b0;
            r_size      <= c_SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_gather    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            r_cross     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_gather   <= '0;
`ifdef MISALIGNED_SPLIT_EN
                        r_cross    <= w_cross;
                        r_state    <= c_ACC0;
`else
                        if (w_misaligned) begin
                            r_state     <= c_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state <= c_ACC0;
                        end
`endif
                    end
                end
                c_ACC0, c_ACC1: begin
                    if (w_last_acc) begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b0;
                        r_rsp_rdata <= r_we ? 32'd0 : w_ext;
                    end else begin
                        // Low-word bytes are kept until the second word arrives.
                        r_gather <= w_gather;
                        r_state  <= c_ACC1;
                    end
                end
                c_RESP: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Scoreboard bench for load_store_unit with a small word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_write_data;
    logic              mem_write_enable;
    logic [31:0]       mem_read_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          c0;

    logic [31:0] mem [0:15];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_idx          (mem_idx),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_read_data = mem[mem_idx[5:2]];

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_data;
        else if (mem_write_enable)
            mem[mem_idx[5:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_error", {31'd0, rsp_error}, {31'd0, mon_e.err});
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic preset(input logic [3:0] i, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_idx  = i;
        pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Drives one request, pushes its expected response, returns 1 after the accepting edge.
    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
        exp_t x;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        x.rdata = exp_rd;
        x.err   = exp_err;
        x.cyc   = cyc + lat;
        sb.push_back(x);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic restore_mem();
        preset(4'd0, 32'h8899AABB);
        preset(4'd1, 32'h11223344);
        preset(4'd15, 32'hA1000000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("rst_mem_idx", mem_idx, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        restore_mem();
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned loads with sign and zero extension
        send(1'b0, 2'b00, 1'b0, 32'd1, 32'd0, 32'hFFFFFFAA, 1'b0, 2);
        send(1'b0, 2'b00, 1'b1, 32'd1, 32'd0, 32'h000000AA, 1'b0, 2);
        send(1'b0, 2'b00, 1'b0, 32'd3, 32'd0, 32'hFFFFFF88, 1'b0, 2);
        send(1'b0, 2'b00, 1'b0, 32'd4, 32'd0, 32'h00000044, 1'b0, 2);
        send(1'b0, 2'b01, 1'b0, 32'd2, 32'd0, 32'hFFFF8899, 1'b0, 2);
        send(1'b0, 2'b01, 1'b1, 32'd0, 32'd0, 32'h0000AABB, 1'b0, 2);
        send(1'b0, 2'b01, 1'b0, 32'd4, 32'd0, 32'h00003344, 1'b0, 2);
        send(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, 32'h8899AABB, 1'b0, 2);
        drain();

        // Half store into upper lanes of word 0
        send(1'b1, 2'b01, 1'b0, 32'd2, 32'h1234BEEF, 32'd0, 1'b0, 2);
        @(negedge clk);
        check("sh_we", {31'd0, mem_write_enable}, 32'd1);
        check("sh_idx", mem_idx, 32'd0);
        check("sh_wdata", mem_write_data, 32'hBEEFAABB);
        drain();
        check("sh_mem0", mem[0], 32'hBEEFAABB);
        check("sh_mem1", mem[1], 32'h11223344);

        // Byte store into lane 1 of word 1
        send(1'b1, 2'b00, 1'b0, 32'd5, 32'hFFFFFF77, 32'd0, 1'b0, 2);
        @(negedge clk);
        check("sb_idx", mem_idx, 32'd4);
        drain();
        check("sb_mem1", mem[1], 32'h11227744);
        check("sb_mem0", mem[0], 32'hBEEFAABB);
        restore_mem();

        // Back-to-back with valid held high
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'd4;
        check("b2b_ready_n", {31'd0, req_ready}, 32'd1);
        c0 = cyc;
        sb.push_back('{rdata: 32'h11223344, err: 1'b0, cyc: c0 + 2});
        @(posedge clk);
        #1 req_addr = 32'd0;
        @(negedge clk);
        check("b2b_ready_n1", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_ready_n2", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_ready_n3", {31'd0, req_ready}, 32'd1);
        sb.push_back('{rdata: 32'h8899AABB, err: 1'b0, cyc: c0 + 5});
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

`ifdef MISALIGNED_SPLIT_EN
        // Word-crossing load, within-word half, and address wrap
        send(1'b0, 2'b10, 1'b0, 32'd2, 32'd0, 32'h33448899, 1'b0, 3);
        send(1'b0, 2'b01, 1'b0, 32'd1, 32'd0, 32'hFFFF99AA, 1'b0, 2);
        send(1'b0, 2'b01, 1'b1, 32'd3, 32'd0, 32'h00004488, 1'b0, 3);
        send(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0, 32'hFFFFBBA1, 1'b0, 3);
        @(negedge clk);
        check("wrap_idx0", mem_idx, 32'hFFFFFFFC);
        @(negedge clk);
        check("wrap_idx1", mem_idx, 32'd0);
        drain();

        // Word-crossing store written one word per cycle
        send(1'b1, 2'b10, 1'b0, 32'd3, 32'hCAFEF00D, 32'd0, 1'b0, 3);
        @(negedge clk);
        check("sw3_we0", {31'd0, mem_write_enable}, 32'd1);
        check("sw3_idx0", mem_idx, 32'd0);
        check("sw3_wdata0", mem_write_data, 32'h0D99AABB);
        @(negedge clk);
        check("sw3_we1", {31'd0, mem_write_enable}, 32'd1);
        check("sw3_idx1", mem_idx, 32'd4);
        check("sw3_wdata1", mem_write_data, 32'h11CAFEF0);
        drain();
        check("sw3_mem0", mem[0], 32'h0D99AABB);
        check("sw3_mem1", mem[1], 32'h11CAFEF0);
        restore_mem();

        // Reset between the two word writes of a crossing store
        send(1'b1, 2'b10, 1'b0, 32'd3, 32'hCAFEF00D, 32'd0, 1'b0, 3);
        @(negedge clk);
        check("abort_we0", {31'd0, mem_write_enable}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_we_drop", {31'd0, mem_write_enable}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_mem0", mem[0], 32'h0D99AABB);
        check("abort_mem1", mem[1], 32'h11223344);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        restore_mem();
`else
        // Misaligned requests are rejected without touching memory
        send(1'b0, 2'b10, 1'b0, 32'd2, 32'd0, 32'd0, 1'b1, 1);
        @(negedge clk);
        check("mis_lw_we", {31'd0, mem_write_enable}, 32'd0);
        drain();
        send(1'b0, 2'b01, 1'b0, 32'd1, 32'd0, 32'd0, 1'b1, 1);
        send(1'b0, 2'b11, 1'b0, 32'd1, 32'd0, 32'd0, 1'b1, 1);
        send(1'b1, 2'b10, 1'b0, 32'd3, 32'hCAFEF00D, 32'd0, 1'b1, 1);
        @(negedge clk);
        check("mis_sw_we", {31'd0, mem_write_enable}, 32'd0);
        check("mis_sw_idx", mem_idx, 32'd0);
        drain();
        check("mis_mem0", mem[0], 32'h8899AABB);
        check("mis_mem1", mem[1], 32'h11223344);
        // Misaligned store followed by aligned load proves the unit recovers
        send(1'b0, 2'b00, 1'b1, 32'd2, 32'd0, 32'h00000099, 1'b0, 2);
        drain();
`endif

        // Reset during the single access cycle of an aligned store
        send(1'b1, 2'b10, 1'b0, 32'd4, 32'hDEADBEEF, 32'd0, 1'b0, 2);
        rst_n = 1'b0;
        #1 check("abort_al_we", {31'd0, mem_write_enable}, 32'd0);
        check("abort_al_idx", mem_idx, 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_al_mem1", mem[1], 32'h11223344);
        check("abort_al_ready", {31'd0, req_ready}, 32'd1);
        check("abort_al_rdata", rsp_rdata, 32'd0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
